// File: rtl/button_event_pkg.sv
// Shared definitions for button_event_gen and its event consumers.
// Optional auto-repeat feature is selected in button_event_gen with BTN_AUTOREPEAT_EN.
package button_event_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_LONG = 2'd2
    } state_e;

    // Bit positions when the event pulses are packed into one vector downstream.
    localparam int EVT_PRESS   = 0;
    localparam int EVT_RELEASE = 1;
    localparam int EVT_LONG    = 2;
    localparam int EVT_REPEAT  = 3;
    localparam int EVT_W       = 4;

endpackage

// File: rtl/button_event_gen_tick_prescaler.sv
// Restartable divide-by-TICK_DIV tick generator.
// tick is high for one cycle when the counter wraps from TICK_DIV-1 to 0
// while enabled; clr restarts the count at 0 and masks the tick.
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == PW'(TICK_DIV - 1));
    assign tick   = en && w_wrap && !clr;

    // Prescale counter: restart on clr, count 0..TICK_DIV-1 while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : (r_cnt + PW'(1));
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/button_event_gen.sv
// Button event generator: turns a debounced, clk-synchronous button level into
// one-shot press / release / long-press / auto-repeat pulses plus a held level.
// Define BTN_AUTOREPEAT_EN to enable repeat_o; otherwise repeat_o is tied 0 and
// LONG is terminal until release.
module button_event_gen
    import button_event_pkg::*;
#(
    parameter int ACTIVE_LEVEL = 1,
    parameter int TICK_DIV     = 1000,
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;

    if (TICK_DIV < 2) begin : g_bad_div
        $error("button_event_gen: TICK_DIV must be >= 2");
    end
    if (CNT_W < $clog2(MAX_TICKS + 1)) begin : g_bad_cnt_w
        $error("button_event_gen: CNT_W too narrow for LONG_TICKS/REPEAT_TICKS");
    end

    // Saturating increment: the hold counter must never wrap back to 0.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : (v + CNT_W'(1));
    endfunction

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_prev_lvl;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [CNT_W-1:0]   w_hold_nxt;
    logic [CNT_W-1:0]   w_hold_inc;
    logic               r_press;
    logic               r_release;
    logic               r_long;
    logic               r_repeat;
    logic               r_held;
    logic               w_press_nxt;
    logic               w_release_nxt;
    logic               w_long_nxt;
    logic               w_repeat_nxt;
    logic               w_presc_clr;
    logic               w_presc_en;
    logic               w_tick;
    logic               w_pressed;
    logic               w_rise;
    logic               w_fall;

    assign w_pressed  = (btn_in == 1'(ACTIVE_LEVEL));
    assign w_rise     = w_pressed && !r_prev_lvl;
    assign w_fall     = !w_pressed && r_prev_lvl;
    assign w_hold_inc = sat_inc(r_hold_cnt);
    assign w_presc_en = (r_state != ST_IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_presc_clr),
        .en    (w_presc_en),
        .tick  (w_tick)
    );

    // Next-state, hold-counter and event decode; release has priority over thresholds.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_presc_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_HOLD;
                    w_press_nxt = 1'b1;
                    w_hold_nxt  = '0;
                    w_presc_clr = 1'b1;
                end else begin
                    w_hold_nxt  = '0;
                end
            end
            ST_HOLD: begin
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_release_nxt = 1'b1;
                    w_hold_nxt    = '0;
                    w_presc_clr   = 1'b1;
                end else if (w_tick) begin
                    if (w_hold_inc >= CNT_W'(LONG_TICKS)) begin
                        w_state_nxt = ST_LONG;
                        w_long_nxt  = 1'b1;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt  = w_hold_inc;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt;
                end
            end
            ST_LONG: begin
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_release_nxt = 1'b1;
                    w_hold_nxt    = '0;
                    w_presc_clr   = 1'b1;
                end else if (w_tick) begin
`ifdef BTN_AUTOREPEAT_EN
                    if (w_hold_inc >= CNT_W'(REPEAT_TICKS)) begin
                        w_repeat_nxt = 1'b1;
                        w_hold_nxt   = '0;
                    end else begin
                        w_hold_nxt   = w_hold_inc;
                    end
`else
                    w_hold_nxt = w_hold_inc;
`endif
                end else begin
                    w_hold_nxt = r_hold_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = '0;
                w_presc_clr = 1'b1;
            end
        endcase
    end

    // State, edge-detect history, hold counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_prev_lvl <= 1'b0;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev_lvl <= w_pressed;
            r_hold_cnt <= w_hold_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
            r_repeat   <= w_repeat_nxt;
            r_held     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign press_o   = r_press;
    assign release_o = r_release;
    assign long_o    = r_long;
    assign repeat_o  = r_repeat;
    assign held_o    = r_held;

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen. Each press episode is turned into its
// expected event list (press, long, repeats, release with exact cycle numbers)
// from the timing rules; a negedge monitor pops and compares as pulses appear.
module tb_button_event_gen;

    localparam int TICK_DIV     = 4;
    localparam int LONG_TICKS   = 3;
    localparam int REPEAT_TICKS = 2;
    localparam int ACTIVE_LEVEL = 1;
    localparam int CNT_W        = 16;
    localparam int LONG_LAT     = LONG_TICKS * TICK_DIV;
    localparam int REP_LAT      = REPEAT_TICKS * TICK_DIV;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;
    localparam int K_REPEAT  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_in;
    logic press_o, release_o, long_o, repeat_o, held_o;
    logic exp_held;

    typedef struct {
        int cyc;
        int kind;
    } evt_t;

    evt_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    button_event_gen #(
        .ACTIVE_LEVEL (ACTIVE_LEVEL),
        .TICK_DIV     (TICK_DIV),
        .LONG_TICKS   (LONG_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .press_o   (press_o),
        .release_o (release_o),
        .long_o    (long_o),
        .repeat_o  (repeat_o),
        .held_o    (held_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Held is simply "button was pressed at the last sampling edge" outside reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_held <= 1'b0;
        else        exp_held <= (btn_in == 1'(ACTIVE_LEVEL));
    end

    function automatic logic lvl(input logic pressed);
        logic a;
        a = 1'(ACTIVE_LEVEL);
        return pressed ? a : ~a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected events for a press first sampled at edge e and held for d samples.
    task automatic push_episode(input int e, input int d);
        exp_q.push_back('{cyc: e, kind: K_PRESS});
        if (d > LONG_LAT) exp_q.push_back('{cyc: e + LONG_LAT, kind: K_LONG});
`ifdef BTN_AUTOREPEAT_EN
        for (int t = LONG_LAT + REP_LAT; t < d; t += REP_LAT)
            exp_q.push_back('{cyc: e + t, kind: K_REPEAT});
`endif
        exp_q.push_back('{cyc: e + d, kind: K_RELEASE});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic episode(input int d, input int gap);
        btn_in = lvl(1'b1);
        push_episode(cyc + 1, d);
        step(d);
        btn_in = lvl(1'b0);
        step(gap);
    endtask

    // Monitor: compare every presented pulse against the head of the expected queue.
    always @(negedge clk) begin
        logic [3:0] pv;
        if (rst_n) begin
            pv = {repeat_o, long_o, release_o, press_o};
            check("held_level", held_o, exp_held);
            check("press_release_excl", press_o & release_o, 1'b0);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_event: kind %0d absent, expected at cycle %0d (now %0d)",
                         exp_q[0].kind, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            for (int k = 0; k < 4; k++) begin
                if (pv[k]) begin
                    n_checks++;
                    if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == k) begin
                        void'(exp_q.pop_front());
                    end else begin
                        n_fail++;
                        $display("FAIL unexpected_event: kind %0d at cycle %0d, required next %0s",
                                 k, cyc, (exp_q.size() > 0) ?
                                 $sformatf("kind %0d at cycle %0d", exp_q[0].kind, exp_q[0].cyc) :
                                 "none");
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bnd[6];
        int d;
        int gap;
        int sel;
        bnd = '{12, 13, 20, 21, 28, 29};

        // Reset with the button already pressed.
        btn_in = lvl(1'b1);
        rst_n  = 1'b0;
        step(3);
        check("rst_press",   press_o,   1'b0);
        check("rst_release", release_o, 1'b0);
        check("rst_long",    long_o,    1'b0);
        check("rst_repeat",  repeat_o,  1'b0);
        check("rst_held",    held_o,    1'b0);
        rst_n = 1'b1;
        episode(5, 3);

        // Directed timing cases.
        episode(30, 4);
        episode(12, 3);
        episode(20, 3);
        episode(1, 1);
        episode(1, 2);
        episode(13, 2);

        // Reset in the middle of a hold, button stays pressed through reset.
        btn_in = lvl(1'b1);
        exp_q.push_back('{cyc: cyc + 1, kind: K_PRESS});
        step(8);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_held",  held_o,  1'b0);
        check("midrst_press", press_o, 1'b0);
        check("midrst_long",  long_o,  1'b0);
        step(2);
        rst_n = 1'b1;
        push_episode(cyc + 1, 6);
        step(6);
        btn_in = lvl(1'b0);
        step(3);

        // Randomized episodes, biased towards the threshold boundaries.
        for (int i = 0; i < 25; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       d = $urandom_range(1, 11);
                1:       d = bnd[$urandom_range(0, 5)];
                2:       d = $urandom_range(14, 45);
                default: d = $urandom_range(1, 3);
            endcase
            gap = $urandom_range(1, 6);
            episode(d, gap);
        end

        step(3);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
